// File: rtl/motor_pkg.sv
// Shared types and constants for the speed-ramped PWM motor drive.
// Contents:
//   SPEED_W       width of a speed / duty level (4 bits, levels 0..15)
//   MAX_LEVEL     highest duty level
//   PWM_SLOTS     duty slots per PWM period
//   speed_t       speed / level type
//   ramp_state_t  ramp controller states
package motor_pkg;

  localparam int SPEED_W   = 4;
  localparam int MAX_LEVEL = 15;
  localparam int PWM_SLOTS = 15;

  typedef logic [SPEED_W-1:0] speed_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_state_t;

endpackage

// File: rtl/pwm_generator.sv
// Slot-based PWM generator. A period is PWM_SLOTS slots of STEP_CYCLES
// clocks each; the output is high during the first 'level' slots.
// Ports:
//   clk              system clock
//   reset            synchronous, active-low reset
//   level            duty level (0 = always low, 15 = always high)
//   pwm              registered PWM output
//   period_boundary  high on the last clock of every PWM period
module pwm_generator
  import motor_pkg::*;
#(
  parameter int STEP_CYCLES = 160
) (
  input  logic   clk,
  input  logic   reset,
  input  speed_t level,
  output logic   pwm,
  output logic   period_boundary
);

  localparam int               SUB_W     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(STEP_CYCLES - 1);
  localparam speed_t           SLOT_LAST = SPEED_W'(PWM_SLOTS - 1);

  logic [SUB_W-1:0] sub_cnt_r;
  speed_t           slot_cnt_r;
  logic             pwm_r;
  logic             sub_wrap_s;
  logic             slot_wrap_s;

  assign sub_wrap_s      = (sub_cnt_r == SUB_LAST);
  assign slot_wrap_s     = (slot_cnt_r == SLOT_LAST);
  assign period_boundary = sub_wrap_s && slot_wrap_s;
  assign pwm             = pwm_r;

  // Sub-slot / slot counters and the registered duty comparator
  always_ff @(posedge clk) begin
    if (!reset) begin
      sub_cnt_r  <= '0;
      slot_cnt_r <= '0;
      pwm_r      <= 1'b0;
    end else begin
      if (sub_wrap_s) begin
        sub_cnt_r <= '0;
        if (slot_wrap_s) begin
          slot_cnt_r <= '0;
        end else begin
          slot_cnt_r <= slot_cnt_r + 4'd1;
        end
      end else begin
        sub_cnt_r  <= sub_cnt_r + SUB_W'(1);
        slot_cnt_r <= slot_cnt_r;
      end
      // Registering the compare keeps the output free of decode glitches
      pwm_r <= (slot_cnt_r < level);
    end
  end

endmodule

// File: rtl/speed_ramp_pwm.sv
// Speed command consumer: latches a 4-bit target speed, slews the applied
// duty level toward it one step every RAMP_PERIODS PWM periods and drives a
// PWM output with duty level/15. Target 0 stops at the next period boundary.
// Ports:
//   clk             system clock
//   reset           synchronous, active-low reset
//   speed_in        speed command data
//   speed_valid_in  strobe qualifying speed_in
//   pwm_out         registered PWM drive
//   level_out       currently applied duty level
//   target_out      latched target level
//   ramping_out     high while the controller is ramping
//   at_target_out   high while the controller is idle at its target
module speed_ramp_pwm
  import motor_pkg::*;
#(
  parameter int STEP_CYCLES  = 160,
  parameter int RAMP_PERIODS = 8
) (
  input  logic   clk,
  input  logic   reset,
  input  speed_t speed_in,
  input  logic   speed_valid_in,
  output logic   pwm_out,
  output speed_t level_out,
  output speed_t target_out,
  output logic   ramping_out,
  output logic   at_target_out
);

  localparam int            RC_W    = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RAMP_PERIODS - 1);
  localparam speed_t        LVL_MAX = SPEED_W'(MAX_LEVEL);

  speed_t          target_r;
  speed_t          level_r;
  logic [RC_W-1:0] ramp_cnt_r;
  ramp_state_t     state_r;
  ramp_state_t     state_next_s;
  logic            ramping_s;
  logic            at_target_s;
  logic            ramping_r;
  logic            at_target_r;
  logic            pb_s;
  logic            pwm_s;
  logic            ramp_last_s;

  pwm_generator #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_pwm (
    .clk             (clk),
    .reset           (reset),
    .level           (level_r),
    .pwm             (pwm_s),
    .period_boundary (pb_s)
  );

  assign ramp_last_s   = (ramp_cnt_r == RC_LAST);
  assign pwm_out       = pwm_s;
  assign level_out     = level_r;
  assign target_out    = target_r;
  assign ramping_out   = ramping_r;
  assign at_target_out = at_target_r;

  // Command capture: the last strobed value becomes the target
  always_ff @(posedge clk) begin
    if (!reset) begin
      target_r <= '0;
    end else if (speed_valid_in) begin
      target_r <= speed_in;
    end else begin
      target_r <= target_r;
    end
  end

  // State register; status flags are registered alongside the state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      ramping_r   <= 1'b0;
      at_target_r <= 1'b1;
    end else begin
      state_r     <= state_next_s;
      ramping_r   <= ramping_s;
      at_target_r <= at_target_s;
    end
  end

  // Next-state logic: direction follows the current target/level relation
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (target_r > level_r) begin
          state_next_s = RAMP_UP;
        end else if (target_r < level_r) begin
          state_next_s = RAMP_DOWN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RAMP_UP: begin
        if (target_r < level_r) begin
          state_next_s = RAMP_DOWN;
        end else if (target_r == level_r) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RAMP_UP;
        end
      end
      RAMP_DOWN: begin
        if (target_r > level_r) begin
          state_next_s = RAMP_UP;
        end else if (target_r == level_r) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RAMP_DOWN;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Status decode for the next state
  always_comb begin
    ramping_s   = (state_next_s != IDLE);
    at_target_s = (state_next_s == IDLE);
  end

  // Level register and ramp pacing; levels only move on a period boundary
  always_ff @(posedge clk) begin
    if (!reset) begin
      level_r    <= '0;
      ramp_cnt_r <= '0;
    end else if (pb_s) begin
      if ((target_r == 4'd0) && (level_r != 4'd0)) begin
        // Stop request bypasses the ramp pacing
        level_r    <= '0;
        ramp_cnt_r <= '0;
      end else begin
        case (state_r)
          RAMP_UP: begin
            if (ramp_last_s) begin
              level_r    <= (level_r != LVL_MAX) ? level_r + 4'd1 : level_r;
              ramp_cnt_r <= '0;
            end else begin
              level_r    <= level_r;
              ramp_cnt_r <= ramp_cnt_r + RC_W'(1);
            end
          end
          RAMP_DOWN: begin
            if (ramp_last_s) begin
              level_r    <= (level_r != 4'd0) ? level_r - 4'd1 : level_r;
              ramp_cnt_r <= '0;
            end else begin
              level_r    <= level_r;
              ramp_cnt_r <= ramp_cnt_r + RC_W'(1);
            end
          end
          default: begin
            level_r    <= level_r;
            ramp_cnt_r <= '0;
          end
        endcase
      end
    end else if (state_r == IDLE) begin
      level_r    <= level_r;
      ramp_cnt_r <= '0;
    end else begin
      // A direction change leaves the pacing counter running
      level_r    <= level_r;
      ramp_cnt_r <= ramp_cnt_r;
    end
  end

endmodule
